// File: rtl/tft_spi_pkg.sv
// Shared opcodes, decoder states, default window and window-commit helper for the TFT SPI responder.
package tft_spi_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 320;

  typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} state_e;

  typedef struct packed {
    logic        apply;
    logic        err;
    logic [15:0] lo;
    logic [15:0] hi;
  } win_upd_t;

  // End is clamped into the panel first; a start beyond the (clamped) end leaves the window alone.
  function automatic win_upd_t win_commit(input logic [15:0] s, input logic [15:0] e,
                                          input logic [15:0] lim);
    win_upd_t    r;
    logic [15:0] e_c;
    e_c     = (e >= lim) ? lim - 16'd1 : e;
    r.apply = (s <= e_c);
    r.err   = (e >= lim) || (s > e_c);
    r.lo    = s;
    r.hi    = e_c;
    return r;
  endfunction

endpackage

// File: rtl/tft_spi_responder_rx.sv
// SPI mode-0 byte receiver: pin synchronisers, SCLK rise detect, MSB-first shifter and bit counter.
// byte_stb lands 3 clk after the pin-level SCLK rise of bit 0; no backpressure, CSn high drops a partial byte.
module spi_byte_rx (
  input  logic       clk,
  input  logic       arstn,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       csn,
  input  logic       dcn,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  // Packed as {sclk, mosi, csn, dcn}; CSn resets to deselected.
  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       byte_stb_q, byte_stb_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_dc_q, byte_dc_d;

  logic sclk_s, mosi_s, csn_s, dcn_s, sclk_rise;

  assign {sclk_s, mosi_s, csn_s, dcn_s} = sync_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_comb begin
    meta_d      = {sclk, mosi, csn, dcn};
    sync_d      = meta_q;
    sclk_prev_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_stb_d  = 1'b0;
    byte_data_d = byte_data_q;
    byte_dc_d   = byte_dc_q;
    if (csn_s) begin
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d   = {shift_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_stb_d  = 1'b1;
        byte_data_d = {shift_q, mosi_s};
        byte_dc_d   = dcn_s;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      meta_q      <= 4'b0010;
      sync_q      <= 4'b0010;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      byte_stb_q  <= 1'b0;
      byte_data_q <= 8'd0;
      byte_dc_q   <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_stb_q  <= byte_stb_d;
      byte_data_q <= byte_data_d;
      byte_dc_q   <= byte_dc_d;
    end
  end

  assign byte_stb  = byte_stb_q;
  assign byte_data = byte_data_q;
  assign byte_dc   = byte_dc_q;

endmodule

// File: rtl/tft_spi_responder.sv
// ILI9341-style SPI responder: decodes CASET/PASET/RAMWR/SWRESET into pixel strobes with screen coordinates.
// Strobes appear 4 clk after the pin-level SCLK rise of the completing bit; no backpressure is possible.
module tft_spi_responder
  import tft_spi_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          csn,
  input  logic          dcn,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [15:0]   pix_color,
  output logic          cmd_valid,
  output logic [7:0]    cmd_byte,
  output logic          win_err
);

  localparam logic [CW-1:0] XMAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] YMAX = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic       byte_stb;
  logic [7:0] byte_data;
  logic       byte_dc;

  spi_byte_rx u_rx (
    .clk       (clk),
    .arstn     (arstn),
    .sclk      (sclk),
    .mosi      (mosi),
    .csn       (csn),
    .dcn       (dcn),
    .byte_stb  (byte_stb),
    .byte_data (byte_data),
    .byte_dc   (byte_dc)
  );

  state_e        state_q, state_d;
  logic [2:0]    arg_cnt_q, arg_cnt_d;
  logic [23:0]   arg_q, arg_d;
  logic [CW-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic          pix_valid_q, pix_valid_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]   pix_color_q, pix_color_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic          win_err_q, win_err_d;
  win_upd_t      upd;

  always_comb begin
    state_d     = state_q;
    arg_cnt_d   = arg_cnt_q;
    arg_d       = arg_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    win_err_d   = win_err_q;
    // arg_q holds {start hi, start lo, end hi}; the incoming byte is end lo.
    upd = win_commit(arg_q[23:8], {arg_q[7:0], byte_data},
                     (state_q == CASET) ? 16'(WIDTH) : 16'(HEIGHT));

    if (byte_stb && !byte_dc) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = byte_data;
      arg_cnt_d   = 3'd0;
      phase_d     = 1'b0;
      case (byte_data)
        CMD_CASET: state_d = CASET;
        CMD_PASET: state_d = PASET;
        CMD_RAMWR: begin
          state_d = RAMWR;
          cx_d    = xs_q;
          cy_d    = ys_q;
        end
        CMD_SWRESET: begin
          state_d   = IDLE;
          xs_d      = '0;
          xe_d      = XMAX;
          ys_d      = '0;
          ye_d      = YMAX;
          cx_d      = '0;
          cy_d      = '0;
          win_err_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end else if (byte_stb) begin
      case (state_q)
        CASET, PASET: begin
          if (arg_cnt_q != 3'd4) begin
            arg_cnt_d = arg_cnt_q + 3'd1;
            arg_d     = {arg_q[15:0], byte_data};
            if (arg_cnt_q == 3'd3) begin
              win_err_d = win_err_q | upd.err;
              if (upd.apply) begin
                if (state_q == CASET) begin
                  xs_d = CW'(upd.lo);
                  xe_d = CW'(upd.hi);
                end else begin
                  ys_d = CW'(upd.lo);
                  ye_d = CW'(upd.hi);
                end
              end
            end
          end
        end
        RAMWR: begin
          if (!phase_q) begin
            hi_d    = byte_data;
            phase_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            pix_valid_d = 1'b1;
            pix_x_d     = cx_q;
            pix_y_d     = cy_q;
            pix_color_d = {hi_q, byte_data};
            if (cx_q == xe_q) begin
              cx_d = xs_q;
              cy_d = (cy_q == ye_q) ? ys_q : cy_q + ONE;
            end else begin
              cx_d = cx_q + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      arg_cnt_q   <= 3'd0;
      arg_q       <= 24'd0;
      xs_q        <= '0;
      xe_q        <= XMAX;
      ys_q        <= '0;
      ye_q        <= YMAX;
      cx_q        <= '0;
      cy_q        <= '0;
      phase_q     <= 1'b0;
      hi_q        <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= 16'd0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'd0;
      win_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      arg_cnt_q   <= arg_cnt_d;
      arg_q       <= arg_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      win_err_q   <= win_err_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign win_err   = win_err_q;

endmodule

// File: tb/tb_tft_spi_responder.sv
// Bench for tft_spi_responder: byte-level reference model of the panel protocol, per-cycle strobe compare.
`timescale 1ns/1ps
module tb_tft_spi_responder;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          sclk = 1'b0, mosi = 1'b0, csn = 1'b1, dcn = 1'b0;
  logic          pix_valid, cmd_valid, win_err;
  logic [CW-1:0] pix_x, pix_y;
  logic [15:0]   pix_color;
  logic [7:0]    cmd_byte;

  tft_spi_responder #(.WIDTH(240), .HEIGHT(320), .CW(CW)) dut (
    .clk(clk), .arstn(arstn), .sclk(sclk), .mosi(mosi), .csn(csn), .dcn(dcn),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .win_err(win_err)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int color; bit err; int idx; } pix_t;
  typedef struct { int op; int idx; } cmd_t;

  pix_t exp_pix[$];
  cmd_t exp_cmd[$];
  pix_t obs[$];
  pix_t o_tmp, e_tmp;
  cmd_t c_tmp;
  int   rise_cyc[int];
  int   cyc = 0;
  int   n_vec = 0, n_chk = 0, n_fail = 0;
  int   hp = 2;
  bit   cs_per_byte = 1'b0;

  // Reference model: window as plain integers, pixel position derived from the pixel index.
  int m_xs, m_xe, m_ys, m_ye, m_cmd, m_n, m_hi;
  bit m_err, m_have_hi;
  int m_args[$];

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      o_tmp.x = int'(pix_x); o_tmp.y = int'(pix_y); o_tmp.color = int'(pix_color);
      o_tmp.err = win_err; o_tmp.idx = 0;
      obs.push_back(o_tmp);
      chk("pix_pending", exp_pix.size() > 0, 1);
      if (exp_pix.size() > 0) begin
        e_tmp = exp_pix.pop_front();
        chk("pix_x", pix_x, e_tmp.x);
        chk("pix_y", pix_y, e_tmp.y);
        chk("pix_color", pix_color, e_tmp.color);
        chk("pix_win_err", win_err, e_tmp.err);
        chk("pix_latency", cyc, rise_cyc[e_tmp.idx] + 4);
      end
    end
    if (cmd_valid === 1'b1) begin
      chk("cmd_pending", exp_cmd.size() > 0, 1);
      if (exp_cmd.size() > 0) begin
        c_tmp = exp_cmd.pop_front();
        chk("cmd_byte", cmd_byte, c_tmp.op);
        chk("cmd_latency", cyc, rise_cyc[c_tmp.idx] + 4);
      end
    end
  end

  task automatic model_reset();
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
    m_cmd = 0; m_n = 0; m_hi = 0; m_err = 1'b0; m_have_hi = 1'b0;
    m_args.delete();
  endtask

  task automatic model_byte(input bit dc, input int b);
    int s, e, lim, w, h;
    pix_t p;
    cmd_t c;
    if (!dc) begin
      c.op = b; c.idx = n_vec;
      exp_cmd.push_back(c);
      m_cmd = b; m_args.delete(); m_have_hi = 1'b0; m_n = 0;
      if (b == 'h01) begin
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; m_err = 1'b0;
      end
    end else if (m_cmd == 'h2A || m_cmd == 'h2B) begin
      m_args.push_back(b);
      if (m_args.size() == 4) begin
        s = m_args[0] * 256 + m_args[1];
        e = m_args[2] * 256 + m_args[3];
        lim = (m_cmd == 'h2A) ? 240 : 320;
        if (s > e) m_err = 1'b1;
        else begin
          if (e >= lim) begin m_err = 1'b1; e = lim - 1; end
          if (s <= e) begin
            if (m_cmd == 'h2A) begin m_xs = s; m_xe = e; end
            else begin m_ys = s; m_ye = e; end
          end
        end
      end
    end else if (m_cmd == 'h2C) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1'b1;
      end else begin
        w = m_xe - m_xs + 1;
        h = m_ye - m_ys + 1;
        p.x = m_xs + m_n % w;
        p.y = m_ys + (m_n / w) % h;
        p.color = m_hi * 256 + b;
        p.err = m_err;
        p.idx = n_vec;
        exp_pix.push_back(p);
        m_n++;
        m_have_hi = 1'b0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic spi_byte(input bit dc, input int b);
    logic [7:0] bv;
    bv = b[7:0];
    n_vec++;
    model_byte(dc, int'(bv));
    dcn = dc;
    if (csn) begin csn = 1'b0; tick(hp); end
    for (int i = 7; i >= 0; i--) begin
      mosi = bv[i];
      tick(hp);
      sclk = 1'b1;
      if (i == 0) rise_cyc[n_vec] = cyc;
      tick(hp);
      sclk = 1'b0;
    end
    if (cs_per_byte) begin tick(1); csn = 1'b1; tick(hp + 1); end
  endtask

  task automatic spi_partial(input int nbits);
    csn = 1'b0;
    tick(hp);
    for (int i = 0; i < nbits; i++) begin
      mosi = 1'($urandom_range(0, 1));
      tick(hp); sclk = 1'b1; tick(hp); sclk = 1'b0;
    end
    tick(1); csn = 1'b1; tick(hp + 2);
  endtask

  task automatic cmd(input int op);  spi_byte(1'b0, op); endtask
  task automatic dat(input int b);   spi_byte(1'b1, b);  endtask

  task automatic win(input int op, input int s, input int e);
    cmd(op); dat(s >> 8); dat(s & 255); dat(e >> 8); dat(e & 255);
  endtask

  task automatic pixels(input int n, input int base);
    cmd('h2C);
    for (int i = 0; i < n; i++) begin dat((base + i) >> 8); dat((base + i) & 255); end
  endtask

  task automatic drain(input string tag);
    tick(12);
    chk({tag, "_pix_drained"}, exp_pix.size(), 0);
    chk({tag, "_cmd_drained"}, exp_cmd.size(), 0);
    chk({tag, "_win_err"}, win_err, m_err);
  endtask

  task automatic chk_obs(input string tag, input int i, input int x, input int y);
    chk({tag, "_have"}, obs.size() > i, 1);
    if (obs.size() > i) begin
      chk({tag, "_x"}, obs[i].x, x);
      chk({tag, "_y"}, obs[i].y, y);
    end
  endtask

  task automatic chk_six(input string tag);
    int lx[6] = '{10, 11, 12, 10, 11, 12};
    int ly[6] = '{20, 20, 20, 21, 21, 21};
    chk({tag, "_count"}, obs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk_obs(tag, i, lx[i], ly[i]);
      if (obs.size() > i) chk({tag, "_color"}, obs[i].color, 'hF800 + i);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, lim, s, e, nargs, nb;
    int a[4];
    model_reset();
    tick(3);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_pix_color", pix_color, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_byte", cmd_byte, 0);
    chk("rst_win_err", win_err, 0);
    arstn = 1'b1;
    tick(3);

    // Six pixels in a 3x2 window, continuous chip select.
    obs.delete();
    win('h2A, 10, 12); win('h2B, 20, 21); pixels(6, 'hF800);
    drain("s1");
    chk_six("s1");
    chk("s1_err", win_err, 0);

    // Reversed window is rejected.
    cmd('h01);
    win('h2A, 5, 3);
    drain("s2a");
    chk("s2_err_set", win_err, 1);
    obs.delete();
    pixels(1, 'h1234);
    drain("s2b");
    chk_obs("s2_pix", 0, 0, 0);
    cmd('h01);
    drain("s2c");
    chk("s2_err_clear", win_err, 0);

    // End column beyond the panel is clamped.
    win('h2A, 0, 300);
    drain("s3a");
    chk("s3_err_set", win_err, 1);
    obs.delete();
    pixels(241, 0);
    drain("s3b");
    chk("s3_count", obs.size(), 241);
    chk_obs("s3_last_col", 239, 239, 0);
    chk_obs("s3_wrap_row", 240, 0, 1);

    // 2x2 window wraps back to its origin.
    cmd('h01);
    win('h2A, 0, 1); win('h2B, 0, 1);
    obs.delete();
    pixels(5, 'h0100);
    drain("s4");
    chk_obs("s4_p2", 2, 0, 1);
    chk_obs("s4_p5", 4, 0, 0);

    // Chip select toggled per byte and a partial byte mid-pixel: same stream as the first case.
    cs_per_byte = 1'b1;
    win('h2A, 10, 12); win('h2B, 20, 21);
    obs.delete();
    cmd('h2C);
    for (int i = 0; i < 6; i++) begin
      dat(('hF800 + i) >> 8);
      if (i == 2) spi_partial(4);
      dat(('hF800 + i) & 255);
    end
    cs_per_byte = 1'b0;
    drain("s5");
    chk_six("s5");

    // Odd RAMWR byte dropped by a command, then reset mid-byte.
    obs.delete();
    cmd('h2C); dat(1); dat(2); dat(3); cmd('h2A);
    drain("s6a");
    chk("s6_pix_count", obs.size(), 1);
    chk("s6_cmd_byte", cmd_byte, 'h2A);
    win('h2A, 3, 4);
    cmd('h2C); dat('hAB);
    drain("s6b");
    csn = 1'b0; tick(hp);
    for (int i = 0; i < 3; i++) begin mosi = 1'b1; tick(hp); sclk = 1'b1; tick(hp); sclk = 1'b0; end
    arstn = 1'b0;
    #1;
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_pix_x", pix_x, 0);
    chk("arst_pix_y", pix_y, 0);
    chk("arst_pix_color", pix_color, 0);
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_cmd_byte", cmd_byte, 0);
    chk("arst_win_err", win_err, 0);
    model_reset();
    csn = 1'b1; sclk = 1'b0;
    tick(3);
    arstn = 1'b1;
    tick(3);
    obs.delete();
    pixels(1, 'h5555);
    drain("s6c");
    chk_obs("s6_default_win", 0, 0, 0);

    // Randomised command/data mix.
    for (int t = 0; t < 120; t++) begin
      hp = $urandom_range(2, 3);
      cs_per_byte = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          op  = $urandom_range(0, 1) ? 'h2A : 'h2B;
          lim = (op == 'h2A) ? 240 : 320;
          s   = $urandom_range(0, lim + 8);
          e   = $urandom_range(0, lim + 8);
          if ($urandom_range(0, 2) == 0) e = s + $urandom_range(0, 3);
          a[0] = s >> 8; a[1] = s & 255; a[2] = e >> 8; a[3] = e & 255;
          nargs = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : 4;
          cmd(op);
          for (int k = 0; k < nargs; k++) dat((k < 4) ? a[k] : $urandom_range(0, 255));
        end
        3, 4, 5: begin
          nb = $urandom_range(0, 16);
          cmd('h2C);
          for (int k = 0; k < nb; k++) dat($urandom_range(0, 255));
        end
        6: cmd('h01);
        7: cmd($urandom_range(0, 255));
        8: begin
          nb = $urandom_range(1, 3);
          for (int k = 0; k < nb; k++) dat($urandom_range(0, 255));
        end
        default: spi_partial($urandom_range(1, 7));
      endcase
    end
    cs_per_byte = 1'b0;
    hp = 2;
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tft_spi_responder.md
Name: tft_spi_responder

Overview:
- SPI-slave model of the ILI9341-style TFT: the responder end of the display link driven by the TFT controller.
- Oversamples SCLK/MOSI/CSn/DCn on clk and assembles bytes.
- Decodes CASET/PASET/RAMWR/SWRESET and emits one pixel-write strobe per RGB565 pixel with its screen coordinate.
- Used as an on-chip loopback/scoreboard target and as a framebuffer feeder for simulation and hardware self-test.

Parameters:
- WIDTH, 240, panel columns; x range 0..WIDTH-1.
- HEIGHT, 320, panel rows; y range 0..HEIGHT-1.
- CW, 16, coordinate width in bits.

Ports:
- clk  in  1  system clock; must be at least 4x SCLK.
- arstn  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock, mode 0, MSB first.
- mosi  in  1  SPI data.
- csn  in  1  chip select, active-low.
- dcn  in  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
- pix_valid  out  1  one-clk strobe per decoded pixel.
- pix_x  out  CW  pixel column, valid with pix_valid.
- pix_y  out  CW  pixel row, valid with pix_valid.
- pix_color  out  16  RGB565 value, first byte = bits 15:8.
- cmd_valid  out  1  one-clk strobe per command byte received.
- cmd_byte  out  8  last command opcode.
- win_err  out  1  sticky flag for an illegal window write; cleared only by reset or SWRESET.

Behaviour:
- Reset (arstn low, asynchronous): all outputs 0; window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1; cursor cx=xs, cy=ys; state IDLE; bit count 0; pixel phase 0.
- Input path:
  - sclk, mosi, csn, dcn pass through 2-flop synchronisers.
  - A rising edge of synced sclk while synced csn=0 shifts in mosi.
  - The 8th bit raises an internal byte strobe with the byte and dcn.
  - Latency: pix_valid/cmd_valid occur 4 clk after the pin-level SCLK rise of the completing bit.
- csn high: bit count cleared and any partial byte discarded. Command context and pixel phase are kept, because the controller may toggle CS per byte.
- Any command byte (dcn=0) pulses cmd_valid, loads cmd_byte, and aborts the current command. Uncommitted CASET/PASET bytes are dropped, and a pending odd RAMWR byte is dropped.
- States:
  - IDLE: data bytes are ignored.
  - CASET (0x2A), PASET (0x2B): collect 4 data bytes (start hi, start lo, end hi, end lo). Commit on the 4th byte. Further data bytes are ignored until the next command.
  - RAMWR (0x2C): on entry the cursor is set to (xs,ys). Byte pairs form a pixel.
  - SWRESET (0x01): window and cursor reset to the reset values, win_err cleared, then IDLE.
  - Any other opcode: IDLE.
- Window commit rules:
  - start > end: window unchanged, win_err set.
  - end >= limit (WIDTH or HEIGHT): end clamped to limit-1, win_err set.
  - start >= limit with end valid is covered by start > end.
- RAMWR pixel stepping:
  - pix_valid is asserted with the current (cx,cy).
  - Then if cx==xe: cx=xs and cy advances, with cy==ye wrapping to ys. Otherwise cx+1.
  - A 1x1 window (xs=xe, ys=ye) repeats the same coordinate.
- Arithmetic is unsigned CW-bit. No coordinate output ever leaves the committed window.
- Byte completing together with csn rising: the byte counts if its 8th edge was sampled before csn went high in the synchronised domain.

Decomposition:
- Package tft_spi_pkg holds:
  - opcode constants CMD_SWRESET=8'h01, CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C;
  - the state enum (IDLE, CASET, PASET, RAMWR);
  - default window constants.
- Sub-module spi_byte_rx: synchronisers, edge detect, shift register and bit counter. Outputs byte_stb, byte_data[7:0], byte_dc. The top level holds the decoder FSM, window registers and cursor.

Test Plan:
- Reset, then CASET 0,10,0,12 + PASET 0,20,0,21 + RAMWR with 6 pixels 0xF800..0xF805 -> pix (10,20)(11,20)(12,20)(10,21)(11,21)(12,21) with the matching colors; win_err=0.
- CASET 0,5,0,3 -> window unchanged, win_err=1. Following RAMWR with 1 pixel -> pix at (0,0). SWRESET -> win_err=0.
- CASET 0,0,1,0x2C (end=300) -> xe clamped to 239, win_err=1. RAMWR with 241 pixels -> pixel 240 at (0,1).
- Window 2x2 at (0,0), RAMWR with 5 pixels -> 5th pixel wraps to (0,0).
- csn pulsed high between every byte, plus one aborted 4-bit partial byte mid-stream -> identical pixel stream to the continuous-CS case.
- RAMWR with 3 bytes then CASET command -> exactly 1 pix_valid; cmd_valid with cmd_byte=0x2A. arstn asserted mid-pixel -> all outputs 0 immediately and the window back to the default.
